// File: rtl/keypad_pkg.sv
// Shared keypad-path constants, event layout and encoder FSM states.
package keypad_pkg;
  localparam int NKEYS        = 16;
  localparam int KEY_IDX_W    = 4;
  localparam int EV_W         = 5;
  localparam int EV_PRESS_BIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } enc_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered head; 1-cycle write-to-read latency.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             vld_q, vld_d;
  logic             wr_fire, rd_fire;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_fire = rd_rdy && !empty;
  assign wr_fire = wr_vld && (!full || rd_fire);
  assign rd_vld  = vld_q;
  assign rd_dat  = head_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head is looked up from next-state storage so a push into an empty FIFO shows next cycle.
    head_d = mem_d[rd_ptr_d];
    vld_d  = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end
endmodule

// File: rtl/key_event_encoder.sv
// Turns sampled key levels into press/release events, one per changed key, lowest index first.
// Event visible 3 cycles after the synchronized strobe edge; full FIFO without a pop drops and sets overflow.
module key_event_encoder
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] btn,
  input  logic             frame_strobe,
  output logic             ev_valid,
  output logic [EV_W-1:0]  ev_data,
  input  logic             ev_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             any_down
);
  logic [NKEYS-1:0]     btn_s1_q, btn_s2_q;
  logic                 strb_s1_q, strb_s2_q, strb_s3_q;
  enc_state_e           state_q, state_d;
  logic [NKEYS-1:0]     prev_q, prev_d;
  logic [NKEYS-1:0]     pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 any_down_q, any_down_d;
  logic                 s_rise;
  logic [KEY_IDX_W-1:0] key_idx;
  logic                 push_vld;
  logic [EV_W-1:0]      push_dat;
  logic                 drop;
  logic                 fifo_full, fifo_empty;

  assign s_rise = strb_s2_q && !strb_s3_q;

  always_comb begin
    key_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) key_idx = KEY_IDX_W'(i);
    end

    state_d   = state_q;
    prev_d    = prev_q;
    pending_d = pending_q;
    push_vld  = 1'b0;
    push_dat  = '0;
    push_dat[EV_PRESS_BIT]    = ~prev_q[key_idx];
    push_dat[KEY_IDX_W-1:0]   = key_idx;

    case (state_q)
      IDLE: if (s_rise) state_d = CAPTURE;
      CAPTURE: begin
        pending_d = btn_s2_q ^ prev_q;
        state_d   = (pending_d != '0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        // prev follows the emitted key even if the FIFO drops it, so it always mirrors key state.
        push_vld           = 1'b1;
        prev_d[key_idx]    = ~prev_q[key_idx];
        pending_d[key_idx] = 1'b0;
        if (pending_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    drop       = push_vld && fifo_full && !(ev_ready && !fifo_empty);
    overflow_d = drop || (overflow_q && !clr_ovf);
    any_down_d = |prev_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      strb_s1_q  <= 1'b0;
      strb_s2_q  <= 1'b0;
      strb_s3_q  <= 1'b0;
      state_q    <= IDLE;
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      any_down_q <= 1'b0;
    end else begin
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      strb_s1_q  <= frame_strobe;
      strb_s2_q  <= strb_s1_q;
      strb_s3_q  <= strb_s2_q;
      state_q    <= state_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      any_down_q <= any_down_d;
    end
  end

  assign overflow = overflow_q;
  assign any_down = any_down_q;

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (ev_ready),
    .rd_vld (ev_valid),
    .rd_dat (ev_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_key_event_encoder.sv
// Directed and randomized checks of key_event_encoder against a per-frame key-diff model.
module tb_key_event_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] btn;
  logic        frame_strobe;
  logic        ev_valid;
  logic [4:0]  ev_data;
  logic        ev_ready;
  logic        overflow;
  logic        clr_ovf;
  logic        any_down;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_prev;
  bit          m_ovf;
  logic [4:0]  exp_q[$];

  key_event_encoder #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .frame_strobe (frame_strobe),
    .ev_valid     (ev_valid),
    .ev_data      (ev_data),
    .ev_ready     (ev_ready),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .any_down     (any_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every key whose level differs from the last reported state yields one
  // event in ascending index order; only the first 'cap' fit, the rest are lost.
  task automatic model_frame(input logic [15:0] nb, input int cap);
    int room;
    room = cap;
    for (int i = 0; i < 16; i++) begin
      if (nb[i] !== m_prev[i]) begin
        if (room > 0) begin
          exp_q.push_back({nb[i], 4'(i)});
          room--;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_prev = nb;
  endtask

  // Every accepted event must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL extra_event: observed %0h expected no event", ev_data);
      end else begin
        chk("event", {27'd0, ev_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_frame(input int low_cycles);
    frame_strobe = 1'b1;
    repeat (3) tick();
    frame_strobe = 1'b0;
    repeat (low_cycles) tick();
  endtask

  task automatic frame(input logic [15:0] nb);
    btn = nb;
    repeat (3) tick();
    model_frame(nb, 99);
    strobe_frame(3);
  endtask

  task automatic drain(input string tag);
    ev_ready = 1'b1;
    repeat (30) tick();
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_valid_low"}, ev_valid, 1'b0);
  endtask

  int          first;
  int          nflip;
  int          idx;
  logic [15:0] nb;

  initial begin
    rst_n = 1'b0; btn = '0; frame_strobe = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    m_prev = '0; m_ovf = 1'b0;
    repeat (3) tick();
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_ev_data", ev_data, 5'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_any_down", any_down, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Key 5 held over several frames, then released
    ev_ready = 1'b1;
    frame(16'h0020);
    repeat (20) tick();
    chk("k5_any_down", any_down, 1'b1);
    frame(16'h0020);
    frame(16'h0020);
    repeat (10) tick();
    chk("k5_held_any_down", any_down, 1'b1);
    chk("k5_held_no_pending", exp_q.size(), 0);
    frame(16'h0000);
    drain("k5");
    chk("k5_release_any_down", any_down, 1'b0);

    // Keys 0, 3, 15 in one frame: latency and back-to-back order
    btn = 16'h8009;
    repeat (3) tick();
    model_frame(btn, 99);
    ev_ready = 1'b1;
    first = -1;
    frame_strobe = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) frame_strobe = 1'b0;
      if (first < 0 && ev_valid === 1'b1) first = c;
      if (c == 5) chk("burst_ev0", ev_data, 5'h10);
      if (c == 6) chk("burst_ev1", ev_data, 5'h13);
      if (c == 7) chk("burst_ev2", ev_data, 5'h1F);
      if (c == 8) chk("burst_end_valid", ev_valid, 1'b0);
    end
    chk("burst_latency", first, 5);
    frame(16'h0000);
    drain("burst");

    // Six presses with no consumer: four kept, two dropped
    ev_ready = 1'b0;
    btn = 16'h0556;
    repeat (3) tick();
    model_frame(btn, 4);
    strobe_frame(20);
    chk("ovf_set", overflow, m_ovf);
    chk("ovf_any_down", any_down, 1'b1);
    chk("ovf_valid", ev_valid, 1'b1);
    chk("ovf_head", ev_data, 5'h11);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Push into full FIFO while a pop happens the same cycle
    btn = 16'h0156;
    repeat (3) tick();
    model_frame(btn, 99);
    frame_strobe = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) frame_strobe = 1'b0;
      if (c == 4) ev_ready = 1'b1;
      if (c == 5) begin
        ev_ready = 1'b0;
        chk("full_pop_ovf", overflow, 1'b0);
        chk("full_pop_valid", ev_valid, 1'b1);
        chk("full_pop_head", ev_data, 5'h12);
      end
    end
    chk("full_pop_ovf_late", overflow, 1'b0);
    drain("full_pop");
    frame(16'h0000);
    drain("release_all");
    chk("release_all_any_down", any_down, 1'b0);
    chk("release_all_ovf", overflow, 1'b0);

    // Strobe and key change arriving mid-drain
    ev_ready = 1'b1;
    btn = 16'h00FF;
    repeat (3) tick();
    model_frame(btn, 99);
    frame_strobe = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 2) frame_strobe = 1'b0;
      if (c == 3) btn = 16'h10FF;
      if (c == 4) frame_strobe = 1'b1;
      if (c == 7) frame_strobe = 1'b0;
    end
    drain("middrain");
    frame(16'h10FF);
    drain("middrain_next");

    // Reset in the middle of a drain, key 9 still held
    ev_ready = 1'b0;
    btn = 16'h0E00;
    repeat (3) tick();
    frame_strobe = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) frame_strobe = 1'b0;
    end
    btn = 16'h0200;
    rst_n = 1'b0;
    #1;
    chk("midrst_ev_valid", ev_valid, 1'b0);
    chk("midrst_ev_data", ev_data, 5'h00);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_any_down", any_down, 1'b0);
    m_prev = '0; m_ovf = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    frame(16'h0200);
    drain("rst_rearm");
    chk("rst_rearm_any_down", any_down, 1'b1);

    // Random frames, at most four changes each, random backpressure
    for (int f = 0; f < 20; f++) begin
      nb = m_prev;
      nflip = $urandom_range(0, 4);
      for (int k = 0; k < nflip; k++) begin
        idx = $urandom_range(0, 15);
        nb[idx] = ~nb[idx];
      end
      btn = nb;
      repeat (3) tick();
      model_frame(nb, 99);
      frame_strobe = 1'b1;
      for (int c = 1; c <= 25; c++) begin
        ev_ready = 1'($urandom_range(0, 1));
        tick();
        if (c == 3) frame_strobe = 1'b0;
      end
      drain("rand");
      chk("rand_any_down", any_down, |m_prev);
      chk("rand_ovf", overflow, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
